// File: rtl/rom_port_arbiter_pkg.sv
// Shared constants and types for the two-port ROM arbiter (fetch port vs MEM-stage data port).
package rom_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic              CHIP_ENABLE  = 1'b1;
  localparam logic              CHIP_DISABLE = 1'b0;

  typedef enum logic {
    ROM_PORT_IF = 1'b0,
    ROM_PORT_D  = 1'b1
  } rom_port_e;

  // One ROM access decision for the current cycle.
  typedef struct packed {
    logic              ce;
    rom_port_e         port;
    logic [ADDR_W-1:0] addr;
  } rom_access_t;

  function automatic logic word_aligned(input logic [ADDR_W-1:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/rom_port_arbiter_starve_counter.sv
// Counts consecutive data grants taken while a fetch is waiting; flags when fetch must win.
module rom_port_arbiter_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic starved
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0] cnt;

  assign starved = (cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!if_req || if_gnt) begin
      cnt <= '0;
    end else if (d_gnt && !starved) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Single-ROM arbiter: data port has priority, fetch port is guaranteed a slot after STARVE_MAX data wins.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  output logic              stall_req
);

  logic        d_mis;
  logic        d_ok;
  logic        starved;
  rom_access_t acc;

  // A misaligned data request never reaches the ROM, so the fetch port may take the slot.
  always_comb begin
    d_mis = ~rst & d_req & ~word_aligned(d_addr);
    d_ok  = d_req & word_aligned(d_addr);
    acc   = '{ce: CHIP_DISABLE, port: ROM_PORT_IF, addr: ZERO_WORD};
    if (!rst) begin
      if (d_ok && !(if_req && starved)) begin
        acc = '{ce: CHIP_ENABLE, port: ROM_PORT_D, addr: d_addr};
      end else if (if_req) begin
        acc = '{ce: CHIP_ENABLE, port: ROM_PORT_IF, addr: if_addr};
      end
    end
  end

  assign d_gnt     = (acc.ce == CHIP_ENABLE) && (acc.port == ROM_PORT_D);
  assign if_gnt    = (acc.ce == CHIP_ENABLE) && (acc.port == ROM_PORT_IF);
  assign rom_ce    = acc.ce;
  assign rom_addr  = acc.addr;
  assign stall_req = ~rst & if_req & ~if_gnt;

  rom_port_arbiter_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .d_gnt   (d_gnt),
    .starved (starved)
  );

  // Read data is captured at the granting edge; rdata holds until the port's next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= ZERO_WORD;
      d_rvalid  <= 1'b0;
      d_rdata   <= ZERO_WORD;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt;
      d_err     <= d_mis;
      if (if_gnt) if_rdata <= rom_inst;
      if (d_gnt) begin
        d_rdata <= rom_inst;
      end else if (d_mis) begin
        d_rdata <= ZERO_WORD;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized and directed bench for rom_port_arbiter against a behavioural arbitration model.
module tb_rom_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall_req;

  logic [31:0] mem [0:63];
  assign rom_inst = mem[rom_addr[7:2]];

  always #5 clk = ~clk;

  rom_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst), .stall_req(stall_req)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (what the ports should show this cycle)
  int          m_starve;
  bit          m_if_rvalid, m_d_rvalid, m_d_err;
  logic [31:0] m_if_rdata, m_d_rdata;
  // Expected combinational decision for the inputs currently applied
  bit          e_if_gnt, e_d_gnt, e_ce, e_stall, e_dmis;
  logic [31:0] e_addr;

  task automatic model_clear();
    m_starve = 0; m_if_rvalid = 0; m_d_rvalid = 0; m_d_err = 0;
    m_if_rdata = 32'h0; m_d_rdata = 32'h0;
  endtask

  task automatic apply(input bit ireq, input logic [31:0] ia, input bit dreq, input logic [31:0] da);
    if_req = ireq; if_addr = ia; d_req = dreq; d_addr = da;
    e_dmis   = dreq && (da[1:0] != 2'b00);
    e_d_gnt  = dreq && !e_dmis && !(ireq && (m_starve == STARVE_MAX));
    e_if_gnt = ireq && !e_d_gnt;
    e_ce     = e_if_gnt || e_d_gnt;
    e_addr   = e_d_gnt ? da : (e_if_gnt ? ia : 32'h0);
    e_stall  = ireq && !e_if_gnt;
  endtask

  task automatic advance();
    @(posedge clk);
    m_if_rvalid = e_if_gnt;
    m_d_rvalid  = e_d_gnt;
    m_d_err     = e_dmis;
    if (e_if_gnt) m_if_rdata = mem[e_addr[7:2]];
    if (e_d_gnt) m_d_rdata = mem[e_addr[7:2]];
    else if (e_dmis) m_d_rdata = 32'h0;
    if (!if_req || e_if_gnt) m_starve = 0;
    else if (e_d_gnt && m_starve < STARVE_MAX) m_starve++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({if_gnt, d_gnt, rom_ce, stall_req} !== 4'b0000) begin
        errors++; $display("FAIL reset_grants got gnt/d/ce/stall=%b exp 0000", {if_gnt, d_gnt, rom_ce, stall_req});
      end
      checks++; if ({if_rvalid, d_rvalid, d_err} !== 3'b000) begin
        errors++; $display("FAIL reset_valids got %b exp 000", {if_rvalid, d_rvalid, d_err});
      end
      checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
        errors++; $display("FAIL reset_rdata got if=%h d=%h exp 0", if_rdata, d_rdata);
      end
    end
    @(posedge clk); #1;
    model_clear();
    apply(0, 0, 0, 0);
    rst = 1'b0;
    advance();
  endtask

  task automatic test_fetch_single();
    apply(1, 32'h10, 0, 0);
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || rom_ce !== 1'b1) begin
      errors++; $display("FAIL fetch_gnt got if=%b d=%b ce=%b exp 1 0 1", if_gnt, d_gnt, rom_ce);
    end
    checks++; if (rom_addr !== 32'h10) begin
      errors++; $display("FAIL fetch_addr got %h exp 00000010", rom_addr);
    end
    advance();
    apply(0, 0, 0, 0);
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== mem[4]) begin
      errors++; $display("FAIL fetch_rdata got v=%b %h exp 1 %h", if_rvalid, if_rdata, mem[4]);
    end
    checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h0) begin
      errors++; $display("FAIL idle_rom got ce=%b addr=%h exp 0 0", rom_ce, rom_addr);
    end
    advance();
  endtask

  task automatic test_starve();
    bit exp_d [6] = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      apply(1, 32'h40, 1, 32'h80);
      @(negedge clk);
      checks++; if (d_gnt !== exp_d[i] || if_gnt !== !exp_d[i]) begin
        errors++; $display("FAIL starve_order cyc %0d got d=%b if=%b exp d=%b", i, d_gnt, if_gnt, exp_d[i]);
      end
      checks++; if (stall_req !== exp_d[i]) begin
        errors++; $display("FAIL starve_stall cyc %0d got %b exp %b", i, stall_req, exp_d[i]);
      end
      advance();
    end
    apply(0, 0, 0, 0);
    advance();
  endtask

  task automatic test_misaligned();
    apply(1, 32'h30, 1, 32'h22);
    @(negedge clk);
    checks++; if (d_gnt !== 1'b0 || if_gnt !== 1'b1 || rom_addr !== 32'h30) begin
      errors++; $display("FAIL mis_gnt got d=%b if=%b addr=%h exp 0 1 00000030", d_gnt, if_gnt, rom_addr);
    end
    advance();
    apply(0, 0, 0, 0);
    @(negedge clk);
    checks++; if (d_err !== 1'b1 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL mis_err got err=%b v=%b rd=%h exp 1 0 0", d_err, d_rvalid, d_rdata);
    end
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== mem[12]) begin
      errors++; $display("FAIL mis_fetch got v=%b %h exp 1 %h", if_rvalid, if_rdata, mem[12]);
    end
    advance();
    @(negedge clk);
    checks++; if (d_err !== 1'b0) begin
      errors++; $display("FAIL mis_pulse got %b exp 0", d_err);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) apply(1, 32'(4 * k), 0, 0);
      else apply(0, 0, 0, 0);
      @(negedge clk);
      if (k < 3) begin
        checks++; if (if_gnt !== 1'b1 || rom_addr !== 32'(4 * k)) begin
          errors++; $display("FAIL b2b_gnt k=%0d got %b %h exp 1 %h", k, if_gnt, rom_addr, 32'(4 * k));
        end
      end
      if (k > 0) begin
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== mem[k-1]) begin
          errors++; $display("FAIL b2b_data k=%0d got v=%b %h exp 1 %h", k, if_rvalid, if_rdata, mem[k-1]);
        end
      end
      advance();
    end
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== mem[2]) begin
      errors++; $display("FAIL b2b_end got v=%b %h exp 0 %h", if_rvalid, if_rdata, mem[2]);
    end
    advance();
  endtask

  task automatic test_reset_midflight();
    apply(1, 32'h44, 1, 32'h48);
    #2 rst = 1'b1;
    #1;
    checks++; if (rom_ce !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL mid_rst_comb got ce=%b if=%b d=%b st=%b exp 0", rom_ce, if_gnt, d_gnt, stall_req);
    end
    @(posedge clk); #1;
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_rst_regs got v=%b%b if=%h d=%h exp 00 0 0", if_rvalid, d_rvalid, if_rdata, d_rdata);
    end
    model_clear();
    apply(0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || rom_ce !== 1'b0) begin
      errors++; $display("FAIL mid_rst_release got v=%b%b ce=%b exp 0", if_rvalid, d_rvalid, rom_ce);
    end
    advance();
  endtask

  task automatic test_random();
    bit          pend = 0;
    logic [31:0] pa = 32'h0;
    for (int c = 0; c < 400; c++) begin
      bit          ireq, dreq;
      logic [31:0] ia, da;
      if (pend) begin
        ireq = 1; ia = pa;
      end else begin
        ireq = ($urandom_range(0, 2) != 0);
        ia = 32'($urandom_range(0, 255));
      end
      dreq = ($urandom_range(0, 3) != 0);
      da = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 4) == 0) da[1:0] = 2'($urandom_range(1, 3));
      apply(ireq, ia, dreq, da);
      @(negedge clk);
      checks++; if (if_gnt !== e_if_gnt || d_gnt !== e_d_gnt) begin
        errors++; $display("FAIL rnd_gnt cyc %0d got if=%b d=%b exp if=%b d=%b", c, if_gnt, d_gnt, e_if_gnt, e_d_gnt);
      end
      checks++; if (rom_ce !== e_ce || rom_addr !== e_addr) begin
        errors++; $display("FAIL rnd_rom cyc %0d got ce=%b %h exp ce=%b %h", c, rom_ce, rom_addr, e_ce, e_addr);
      end
      checks++; if (stall_req !== e_stall) begin
        errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", c, stall_req, e_stall);
      end
      checks++; if (if_rvalid !== m_if_rvalid || if_rdata !== m_if_rdata) begin
        errors++; $display("FAIL rnd_if cyc %0d got %b %h exp %b %h", c, if_rvalid, if_rdata, m_if_rvalid, m_if_rdata);
      end
      checks++; if (d_rvalid !== m_d_rvalid || d_rdata !== m_d_rdata || d_err !== m_d_err) begin
        errors++; $display("FAIL rnd_d cyc %0d got %b %h e%b exp %b %h e%b", c, d_rvalid, d_rdata, d_err,
                           m_d_rvalid, m_d_rdata, m_d_err);
      end
      pend = ireq && !e_if_gnt;
      pa = ia;
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    model_clear();
    test_reset();
    test_fetch_single();
    test_starve();
    test_misaligned();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data-port grants while a fetch request is pending.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port if_req, input, 1: fetch-port request, level, held until granted.
REQ-005 SHALL have port if_addr, input, 32 (`InstAddrBus): fetch byte address.
REQ-006 SHALL have port if_gnt, output, 1: fetch granted this cycle.
REQ-007 SHALL have port if_rvalid, output, 1: if_rdata valid, one cycle after if_gnt.
REQ-008 SHALL have port if_rdata, output, 32 (`InstBus): fetched word.
REQ-009 SHALL have port d_req, input, 1: data-port (MEM-stage ROM read) request, level.
REQ-010 SHALL have port d_addr, input, 32: data byte address.
REQ-011 SHALL have ports d_gnt, d_rvalid, d_rdata (32) and d_err (1), all outputs: same semantics as the fetch port; d_err is a one-cycle pulse on misalignment.
REQ-012 SHALL have port rom_ce, output, 1: ROM chip enable (`ChipEnable/`ChipDisable).
REQ-013 SHALL have port rom_addr, output, 32: ROM byte address.
REQ-014 SHALL have port rom_inst, input, 32: combinational ROM read data.
REQ-015 SHALL have port stall_req, output, 1: to pipeline ctrl; high while if_req is high and if_gnt is low.

Function
REQ-016 SHALL issue at most one ROM access per cycle; grant, rom_ce and rom_addr are combinational from the request inputs and registered state.
REQ-017 SHALL, with only one valid request, grant that requester.
REQ-018 SHALL, with both requests valid, grant data unless starve_cnt == STARVE_MAX, in which case grant fetch.
REQ-019 SHALL increment starve_cnt on each data grant while if_req is high, and clear it on any fetch grant or when if_req is low; the counter is saturating, width clog2(STARVE_MAX+1).
REQ-020 SHALL treat d_req with d_addr[1:0] != 2'b00 as misaligned: no ROM access, no d_gnt, d_err pulses the next cycle, d_rdata = `ZeroWord, and the fetch port may use the cycle.
REQ-021 SHALL drive rom_ce = `ChipDisable and rom_addr = `ZeroWord when nothing is granted.
REQ-022 SHALL register rom_inst into the granted port's rdata at the granting edge; the rvalid of that port is high for exactly the next cycle.
REQ-023 SHALL hold each rdata between grants; the non-granted port's rvalid is 0.
REQ-024 SHALL support back-to-back grants every cycle with full throughput (1 word/cycle).
REQ-025 SHALL ignore if_addr[1:0]; fetch is never flagged misaligned.

Reset
REQ-026 SHALL, on rst high and asynchronously, clear starve_cnt, all rvalid/d_err to 0 and all rdata to `ZeroWord.
REQ-027 SHALL hold all grants low, rom_ce = `ChipDisable and stall_req = 0 while rst is high.
REQ-028 SHALL drop a read in flight when reset is asserted mid-operation: no rvalid after reset release for a grant made before reset.

Structure
REQ-029 SHALL take `ZeroWord, `InstAddrBus, `InstBus, `ChipEnable and `ChipDisable from the shared defines.v; add `RomPortIf=1'b0 and `RomPortD=1'b1 there.
REQ-030 SHALL be implemented as a single module; an optional sub-module starve_counter may hold REQ-019.

Verification
REQ-031 SHALL verify: if_req=1, if_addr=0x10, d_req=0 -> if_gnt=1, rom_addr=0x10, and next cycle if_rvalid=1 with if_rdata = mem[4].
REQ-032 SHALL verify: both requests held 6 cycles, STARVE_MAX=4 -> grant order D,D,D,D,IF,D; stall_req high on the first 4 cycles.
REQ-033 SHALL verify: d_req=1, d_addr=0x22, if_req=1 -> d_gnt=0, if_gnt=1 the same cycle, and d_err=1 for one cycle next.
REQ-034 SHALL verify: rst asserted asynchronously between a grant and the next edge -> rvalid stays 0, rdata=0x00000000, rom_ce disabled.
REQ-035 SHALL verify: fetch-only requests at 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive if_rvalid pulses with matching words.
